// File: rtl/ecc_106_rd_err_stage.sv
// ecc_106_rd_err_stage: 2-entry skid buffer for ECC read data with error counters and a sticky irq.
// Optional first-error log is compiled in with ECC_106_ERR_LOG_EN.
module ecc_106_rd_err_stage #(
  parameter int DATA_WIDTH = 106,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic                  in_ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sbit_err,
  output logic                  out_dbit_err,
  output logic                  out_ecc_fault,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  err_irq
`ifdef ECC_106_ERR_LOG_EN
  ,
  output logic                  log_vld,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_dbit,
  output logic                  log_fault
`endif
);
  localparam int W = DATA_WIDTH + 3;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [W-1:0] head, skid, in_word;
  logic rdy_q, acc, pop, ld_head, ld_skid, from_skid;
  assign in_word = {in_data, in_sbit_err, in_dbit_err, in_ecc_fault};
  assign in_rdy = rdy_q;
  assign out_vld = state != EMPTY;
  assign acc = in_vld & rdy_q;
  assign pop = out_vld & out_rdy;
  always_comb begin
    state_nx = state;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_nx = acc ? ONE : EMPTY;
        ld_head = acc;
      end
      ONE: begin
        state_nx = (acc && !pop) ? TWO : (!acc && pop) ? EMPTY : ONE;
        ld_head = acc & pop;
        ld_skid = acc & ~pop;
      end
      TWO: begin
        state_nx = pop ? ONE : TWO;
        ld_head = pop;
        from_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nx;
      rdy_q <= state_nx != TWO;
    end
  // storage is unreset; the output mux hides stale contents while empty
  always_ff @(posedge clk) begin
    if (ld_head) head <= from_skid ? skid : in_word;
    if (ld_skid) skid <= in_word;
  end
  assign {out_data, out_sbit_err, out_dbit_err, out_ecc_fault} = out_vld ? head : '0;
  function automatic logic [CNT_WIDTH-1:0] cnt_nx(input logic [CNT_WIDTH-1:0] c, input logic hit, input logic z);
    return z ? CNT_WIDTH'(hit) : (hit && c != '1) ? c + 1'b1 : c;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
      fault_cnt <= '0;
      err_irq <= 1'b0;
    end else begin
      sbit_cnt <= cnt_nx(sbit_cnt, acc & in_sbit_err, clr);
      dbit_cnt <= cnt_nx(dbit_cnt, acc & in_dbit_err, clr);
      fault_cnt <= cnt_nx(fault_cnt, acc & in_ecc_fault, clr);
      err_irq <= (err_irq & ~clr) | (acc & (in_dbit_err | in_ecc_fault));
    end
`ifdef ECC_106_ERR_LOG_EN
  logic hit_any;
  assign hit_any = acc & (in_sbit_err | in_dbit_err | in_ecc_fault);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      log_vld <= 1'b0;
      log_addr <= '0;
      log_dbit <= 1'b0;
      log_fault <= 1'b0;
    end else if (hit_any && (clr || !log_vld)) begin
      log_vld <= 1'b1;
      log_addr <= in_addr;
      log_dbit <= in_dbit_err;
      log_fault <= in_ecc_fault;
    end else if (clr) begin
      log_vld <= 1'b0;
    end
`else
  logic unused_addr;
  assign unused_addr = ^in_addr;
`endif
endmodule

// File: tb/tb_ecc_106_rd_err_stage.sv
// tb_ecc_106_rd_err_stage: directed vectors against a queue-based model of the read error stage.
module tb_ecc_106_rd_err_stage;
  localparam int DW = 106;
  localparam int AW = 10;
  localparam int CW = 4;
  localparam int MAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic in_vld = 0, in_rdy, out_vld, out_rdy = 1, clr = 0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0, out_data;
  logic in_sbit_err = 0, in_dbit_err = 0, in_ecc_fault = 0;
  logic out_sbit_err, out_dbit_err, out_ecc_fault, err_irq;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
`ifdef ECC_106_ERR_LOG_EN
  logic log_vld, log_dbit, log_fault;
  logic [AW-1:0] log_addr;
`endif
  int n_vec = 0, n_err = 0;

  ecc_106_rd_err_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
    .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
    .in_ecc_fault(in_ecc_fault), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
    .out_ecc_fault(out_ecc_fault), .clr(clr), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .err_irq(err_irq)
`ifdef ECC_106_ERR_LOG_EN
    , .log_vld(log_vld), .log_addr(log_addr), .log_dbit(log_dbit), .log_fault(log_fault)
`endif
  );

  always #5 clk = ~clk;

  // model: FIFO contents as a queue, counters as saturating integers
  logic [DW+2:0] q[$];
  int m_s = 0, m_d = 0, m_f = 0;
  bit m_irq = 0, m_lv = 0, m_ld = 0, m_lf = 0;
  logic [AW-1:0] m_la = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_s = 0; m_d = 0; m_f = 0;
      m_irq = 0; m_lv = 0; m_ld = 0; m_lf = 0; m_la = '0;
    end else begin
      bit acc, pop;
      acc = in_vld && q.size() < 2;
      pop = q.size() > 0 && out_rdy;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({in_data, in_sbit_err, in_dbit_err, in_ecc_fault});
      if (clr) begin m_s = 0; m_d = 0; m_f = 0; m_lv = 0; end
      if (acc && in_sbit_err && m_s < MAX) m_s++;
      if (acc && in_dbit_err && m_d < MAX) m_d++;
      if (acc && in_ecc_fault && m_f < MAX) m_f++;
      m_irq = (m_irq && !clr) || (acc && (in_dbit_err || in_ecc_fault));
      if (acc && (in_sbit_err || in_dbit_err || in_ecc_fault) && !m_lv) begin
        m_lv = 1; m_la = in_addr; m_ld = in_dbit_err; m_lf = in_ecc_fault;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_vld", 128'(out_vld), 128'(q.size() > 0));
    chk("in_rdy", 128'(in_rdy), 128'(q.size() < 2));
    chk("out_word", 128'({out_data, out_sbit_err, out_dbit_err, out_ecc_fault}),
        q.size() > 0 ? 128'(q[0]) : 128'(0));
    chk("sbit_cnt", 128'(sbit_cnt), 128'(m_s));
    chk("dbit_cnt", 128'(dbit_cnt), 128'(m_d));
    chk("fault_cnt", 128'(fault_cnt), 128'(m_f));
    chk("err_irq", 128'(err_irq), 128'(m_irq));
`ifdef ECC_106_ERR_LOG_EN
    chk("log", 128'({log_vld, log_addr, log_dbit, log_fault}), 128'({m_lv, m_la, m_ld, m_lf}));
`endif
  end

  function automatic logic [DW-1:0] mkd(input int i);
    return {32'hA5A50000 + 32'(i), 32'h12345678 ^ 32'(i), 42'(i * 7 + 3)};
  endfunction

  task automatic cyc(input bit v, input int a, input int d, input bit s, input bit db,
                     input bit f, input bit ordy, input bit c);
    in_vld = v; in_addr = AW'(a); in_data = mkd(d);
    in_sbit_err = s; in_dbit_err = db; in_ecc_fault = f; out_rdy = ordy; clr = c;
    @(posedge clk); #1;
    in_vld = 0; clr = 0; in_sbit_err = 0; in_dbit_err = 0; in_ecc_fault = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 128'(in_rdy), 128'(1));
    chk("rst_out_vld", 128'(out_vld), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_cnt", 128'({sbit_cnt, dbit_cnt, fault_cnt, err_irq}), 128'(0));
    rst = 0;
    // clean stream at full rate
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("latency", 128'(out_data), 128'(mkd(0)));
    for (int i = 1; i < 8; i++) cyc(1, i, i, 0, 0, 0, 1, 0);
    chk("last_word", 128'(out_data), 128'(mkd(7)));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("clean_cnt", 128'({sbit_cnt, dbit_cnt, fault_cnt, err_irq}), 128'(0));
    // backpressure: third word must wait
    cyc(1, 10, 10, 0, 0, 0, 0, 0);
    chk("one_rdy", 128'(in_rdy), 128'(1));
    cyc(1, 11, 11, 0, 0, 0, 0, 0);
    chk("two_rdy", 128'(in_rdy), 128'(0));
    cyc(1, 12, 12, 0, 0, 0, 0, 0);
    chk("hold", 128'(out_data), 128'(mkd(10)));
    cyc(1, 12, 12, 0, 0, 0, 1, 0);
    chk("drain1", 128'(out_data), 128'(mkd(11)));
    cyc(1, 12, 12, 0, 0, 0, 1, 0);
    chk("drain2", 128'(out_data), 128'(mkd(12)));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // error counting and irq
    for (int i = 0; i < 3; i++) cyc(1, 20 + i, 20 + i, 1, 0, 0, 1, 0);
    chk("sbit_no_irq", 128'(err_irq), 128'(0));
    cyc(1, 23, 23, 0, 1, 1, 1, 0);
    chk("cnts", 128'({sbit_cnt, dbit_cnt, fault_cnt, err_irq}), 128'({4'd3, 4'd1, 4'd1, 1'b1}));
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("clr", 128'({sbit_cnt, dbit_cnt, fault_cnt, err_irq}), 128'(0));
    // saturation and clr-with-hit
    for (int i = 0; i < 20; i++) cyc(1, 30 + i, 30 + i, 1, 0, 0, 1, 0);
    chk("sat", 128'(sbit_cnt), 128'(15));
    cyc(1, 50, 50, 1, 0, 0, 1, 1);
    chk("clr_hit", 128'(sbit_cnt), 128'(1));
    // first-error log
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 'h005, 60, 1, 0, 0, 1, 0);
    cyc(1, 'h1A0, 61, 0, 1, 0, 1, 0);
`ifdef ECC_106_ERR_LOG_EN
    chk("log1", 128'({log_vld, log_addr, log_dbit}), 128'({1'b1, 10'h005, 1'b0}));
`endif
    cyc(1, 'h033, 62, 0, 0, 1, 1, 1);
    chk("irq_clr_set", 128'(err_irq), 128'(1));
`ifdef ECC_106_ERR_LOG_EN
    chk("log2", 128'({log_vld, log_addr, log_fault}), 128'({1'b1, 10'h033, 1'b1}));
`endif
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // reset while full
    cyc(1, 70, 70, 1, 0, 0, 0, 0);
    cyc(1, 71, 71, 0, 1, 0, 0, 0);
    chk("full", 128'(in_rdy), 128'(0));
    rst = 1;
    #1;
    chk("mid_rst", 128'({out_vld, in_rdy}), 128'({1'b0, 1'b1}));
    chk("mid_rst_cnt", 128'({sbit_cnt, dbit_cnt, fault_cnt, err_irq}), 128'(0));
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 80, 80, 0, 0, 0, 1, 0);
    chk("post_rst", 128'(out_data), 128'(mkd(80)));
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ecc_106_rd_err_stage.md
ECC_106_RD_ERR_STAGE -- requirements
Module: ecc_106_rd_err_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 106, width of the corrected read data.
REQ-002 Parameter ADDR_WIDTH, default 10, width of the read address carried with each word.
REQ-003 Parameter CNT_WIDTH, default 16, width of each error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_vld  input  1  upstream word valid.
REQ-007 in_rdy  output  1  stage can accept a word; driven directly from a register.
REQ-008 in_addr  input  ADDR_WIDTH  read address of the word.
REQ-009 in_data  input  DATA_WIDTH  corrected data from the ECC check/fault-detect stage.
REQ-010 in_sbit_err / in_dbit_err / in_ecc_fault  input  1 each  per-word single-bit, double-bit and checker-mismatch flags.
REQ-011 out_vld  output  1; out_rdy  input  1  downstream handshake.
REQ-012 out_data  output  DATA_WIDTH; out_sbit_err / out_dbit_err / out_ecc_fault  output  1 each; flags travel with their word.
REQ-013 clr  input  1  single-cycle pulse; clears counters, interrupt and log.
REQ-014 sbit_cnt / dbit_cnt / fault_cnt  output  CNT_WIDTH  error counters.
REQ-015 err_irq  output  1  sticky interrupt.

Function
REQ-016 The datapath SHALL be a 2-entry skid buffer with states EMPTY, ONE, TWO.
- Transfer in: in_vld & in_rdy. Transfer out: out_vld & out_rdy.
REQ-017 State transitions SHALL be:
- EMPTY + in -> ONE.
- ONE + in without out -> TWO.
- ONE + out without in -> EMPTY.
- ONE + in + out -> ONE.
- TWO + out -> ONE.
- TWO never accepts.
REQ-018 in_rdy SHALL be 1 exactly when the registered state is not TWO.
REQ-019 out_vld SHALL be 1 exactly when the state is ONE or TWO.
REQ-020 Latency SHALL be 1 cycle: a word accepted in cycle N appears on the out_* ports in cycle N+1 when the buffer was EMPTY.
REQ-021 Ordering SHALL be FIFO, with no loss or duplication.
REQ-022 Data and flags SHALL be held stable while out_vld=1 and out_rdy=0.
REQ-023 Sustained throughput SHALL be 1 word per cycle when out_rdy stays 1.
REQ-024 Counters SHALL increment by 1 per accepted word whose matching flag is set.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- One word with several flags set increments each matching counter.
REQ-025 clr SHALL zero all counters, with one exception: if the same cycle accepts a flagged word, the matching counter loads 1.
REQ-026 err_irq SHALL set on an accepted word with in_dbit_err=1 or in_ecc_fault=1.
- It stays set until clr; a set event in the clr cycle leaves it 1.
- Single-bit errors do not raise err_irq.
REQ-027 Counters and err_irq SHALL update at acceptance time, independent of out_rdy.

Reset
REQ-028 While rst=1, the state SHALL be EMPTY and in_rdy SHALL be 1.
REQ-029 While rst=1, out_vld=0, all counters=0 and err_irq=0.
REQ-030 Data storage SHALL not require reset; out_data and out_* flags SHALL read 0 after reset.
REQ-031 Reset asserted mid-operation SHALL discard buffered words immediately, with no output handshake.

Configuration
REQ-032 Macro ECC_106_ERR_LOG_EN compiled in SHALL add four outputs: log_vld (1), log_addr (ADDR_WIDTH), log_dbit (1), log_fault (1).
- On the first accepted word with any flag set while log_vld=0, the block captures that word's address and flags and sets log_vld.
- Later errors do not overwrite the log.
- clr clears log_vld; an error in the clr cycle is captured.
- All log outputs reset to 0.
REQ-033 Without ECC_106_ERR_LOG_EN, these four ports and their logic SHALL not exist; all other behaviour is unchanged.

Verification
REQ-034 Reset, then 8 clean words with out_rdy=1 -> outputs appear 1 cycle later in order; counters stay 0; err_irq=0.
REQ-035 out_rdy=0, 3 words offered -> first 2 accepted, in_rdy=0 from the cycle after the 2nd acceptance; out_rdy=1 -> words drain in order.
REQ-036 3 words with sbit, 1 with dbit+fault -> sbit_cnt=3, dbit_cnt=1, fault_cnt=1, err_irq=1; clr -> all 0.
REQ-037 CNT_WIDTH=4, 20 sbit words -> sbit_cnt holds at 15; clr together with an sbit word -> sbit_cnt=1.
REQ-038 With ECC_106_ERR_LOG_EN: sbit at address 0x005, then dbit at 0x1A0 -> log_addr=0x005, log_dbit=0; after clr, a fault at 0x033 -> log_addr=0x033, log_fault=1.
REQ-039 rst pulsed while state is TWO -> out_vld=0 and in_rdy=1 in the same cycle; counters=0.
